// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared memory-stage encodings for the MIPS pipeline
package mips_pkg;

  localparam logic [1:0] MS_BYTE = 2'b00;
  localparam logic [1:0] MS_HALF = 2'b01;
  localparam logic [1:0] MS_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_load_align.sv
// rtl/mem_access_load_align.sv - load lane select and extension, built only with MEM_SUBWORD_EN
`ifdef MEM_SUBWORD_EN
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      MS_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      MS_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule
`endif

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage req/ack data-memory access unit; sub-word support under MEM_SUBWORD_EN
module mem_access
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memreadm,
  input  logic        memwritem,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  input  logic [1:0]  memsizem,
  input  logic        memsignedm,
  output logic        stallm,
  output logic [31:0] rdm,
  output logic        misalignm,
  output logic        buserrm,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  mem_state_t  r_state;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdm;
  logic        r_buserr;

  logic        w_access;
  logic        w_misalign;
  logic        w_start;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign w_access = memreadm | memwritem;

`ifdef MEM_SUBWORD_EN
  logic [1:0] r_addr_lo;
  logic [1:0] r_size;
  logic       r_signed;

  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = writedatam;
    case (memsizem)
      MS_BYTE: begin
        w_be    = 4'b0001 << aluoutm[1:0];
        w_wdata = {4{writedatam[7:0]}};
      end
      MS_HALF: begin
        w_misalign = aluoutm[0];
        w_be       = aluoutm[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{writedatam[15:0]}};
      end
      default: w_misalign = |aluoutm[1:0];
    endcase
    if (!memwritem) w_be = 4'b1111;
  end

  // Lane/size/sign are latched with the request so the ack can arrive any REQ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_lo <= 2'b00;
      r_size    <= 2'b00;
      r_signed  <= 1'b0;
    end else if (w_start) begin
      r_addr_lo <= aluoutm[1:0];
      r_size    <= memsizem;
      r_signed  <= memsignedm;
    end
  end

  load_align u_load_align (
    .i_rdata  (dmem_rdata),
    .i_addr_lo(r_addr_lo),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ldata)
  );
`else
  logic w_unused_cfg;

  assign w_misalign   = |aluoutm[1:0];
  assign w_be         = 4'b1111;
  assign w_wdata      = writedatam;
  assign w_ldata      = dmem_rdata;
  assign w_unused_cfg = ^{memsizem, memsignedm};
`endif

  assign w_start   = (r_state == IDLE) & w_access & ~w_misalign;
  assign stallm    = w_start | (r_state == REQ);
  assign misalignm = (r_state == IDLE) & w_access & w_misalign;
  assign rdm       = (r_state == DONE) ? r_rdm : 32'd0;
  assign buserrm   = r_buserr;

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 8'd0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_be     <= 4'd0;
      r_rdm    <= 32'd0;
      r_buserr <= 1'b0;
    end else begin
      r_buserr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_we    <= memwritem;
            r_addr  <= {aluoutm[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_cnt   <= 8'd0;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_rdm   <= r_we ? 32'd0 : w_ldata;
          end else if (r_cnt == LAST_CNT) begin
            r_state  <= DONE;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_rdm    <= 32'd0;
            r_buserr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          // Pipeline advances on this edge, so the held instruction is never reissued.
          r_state <= IDLE;
          r_rdm   <= 32'd0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access (TIMEOUT = 4)
module tb_mem_access;
  import mips_pkg::*;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic        memreadm, memwritem, memsignedm;
  logic [31:0] aluoutm, writedatam;
  logic [1:0]  memsizem;
  logic        stallm, misalignm, buserrm;
  logic [31:0] rdm;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] e_rdm;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .memreadm(memreadm), .memwritem(memwritem),
    .aluoutm(aluoutm), .writedatam(writedatam),
    .memsizem(memsizem), .memsignedm(memsignedm),
    .stallm(stallm), .rdm(rdm), .misalignm(misalignm), .buserrm(buserrm),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                             input logic [31:0] rdata, input int waits, input logic [31:0] e_rdm,
                             input logic [3:0] e_be, input logic [31:0] e_wdata, input logic e_mis);
    vec_t t;
    t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.size = size; t.sgn = sgn;
    t.rdata = rdata; t.waits = waits; t.e_rdm = e_rdm; t.e_be = e_be;
    t.e_wdata = e_wdata; t.e_mis = e_mis;
    return t;
  endfunction

  // Reference: access width in bytes, lanes and extension from plain arithmetic.
  function automatic vec_t model(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] rdata, input int waits);
    vec_t t;
    int w, off;
    logic [63:0] m;
    logic [31:0] unit, rep, val;
`ifdef MEM_SUBWORD_EN
    w = (size == MS_BYTE) ? 1 : (size == MS_HALF) ? 2 : 4;
`else
    w = 4;
`endif
    off  = int'(addr % 4);
    m    = (64'd1 << (8 * w)) - 64'd1;
    unit = wdata & m[31:0];
    rep  = 32'd0;
    for (int i = 0; i < 4; i += w) rep |= unit << (8 * i);
    val = (rdata >> (8 * off)) & m[31:0];
    if (sgn && w < 4 && val[8 * w - 1]) val |= ~m[31:0];
    t = v(rd, wr, addr, wdata, size, sgn, rdata, waits, 32'd0, 4'hF, rep, (addr % w) != 0);
    if (wr) t.e_be = 4'(((1 << w) - 1) << off);
    if (!t.e_mis && !wr && waits < TO) t.e_rdm = val;
    return t;
  endfunction

  task automatic run(input vec_t t);
    int  reqcnt, j, exp_req;
    bit  good;
    logic berr;
    berr    = !t.e_mis && t.waits >= TO;
    exp_req = berr ? TO : t.waits + 1;
    memreadm = t.rd; memwritem = t.wr; aluoutm = t.addr; writedatam = t.wdata;
    memsizem = t.size; memsignedm = t.sgn;
    #1;
    chk("stall_c0", stallm, !t.e_mis);
    chk("misalign", misalignm, t.e_mis);
    chk("rdm_idle", rdm, 0);
    chk("req_c0", dmem_req, 0);
    @(posedge clk); #1;
    if (t.e_mis) begin
      chk("req_mis", dmem_req, 0);
      chk("we_mis", dmem_we, 0);
      memreadm = 0; memwritem = 0;
      @(posedge clk); #1;
      return;
    end
    reqcnt = 0; j = 0; good = 1;
    while (dmem_req === 1'b1 && j < TO + 2) begin
      reqcnt++;
      if (dmem_addr !== (t.addr & ~32'd3) || dmem_be !== t.e_be || dmem_we !== t.wr ||
          stallm !== 1'b1 || (t.wr && dmem_wdata !== t.e_wdata)) good = 0;
      dmem_ack   = (j == t.waits);
      dmem_rdata = (j == t.waits) ? t.rdata : $urandom;
      @(posedge clk); #1;
      dmem_ack = 0;
      j++;
    end
    chk("req_fields", good, 1);
    chk("req_cycles", reqcnt, exp_req);
    chk("stall_done", stallm, 0);
    chk("rdm_done", rdm, t.e_rdm);
    chk("buserr_done", buserrm, berr);
    memreadm = 0; memwritem = 0;
    dmem_ack = 1;
    @(posedge clk); #1;
    dmem_ack = 0;
    chk("req_after", dmem_req, 0);
    chk("buserr_after", buserrm, 0);
    chk("stall_after", stallm, 0);
  endtask

  initial begin
    rst_n = 0; memreadm = 0; memwritem = 0; aluoutm = 0; writedatam = 0;
    memsizem = 0; memsignedm = 0; dmem_ack = 0; dmem_rdata = 0;

    tbl.push_back(v(1, 0, 32'h100, 0, MS_WORD, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 4'hF, 0, 0));
    tbl.push_back(v(1, 0, 32'h102, 0, MS_WORD, 0, 32'h1, 0, 0, 4'hF, 0, 1));
    tbl.push_back(v(1, 0, 32'h200, 0, MS_WORD, 0, 32'h12345678, 10, 0, 4'hF, 0, 0));
    tbl.push_back(v(1, 0, 32'h300, 0, MS_WORD, 0, 32'h0BADF00D, 3, 32'h0BADF00D, 4'hF, 0, 0));
    tbl.push_back(v(1, 1, 32'h10, 32'h11223344, MS_WORD, 0, 32'hFFFFFFFF, 2, 0, 4'hF, 32'h11223344, 0));
    tbl.push_back(v(1, 0, 32'h20, 0, 2'b11, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 4'hF, 0, 0));
    tbl.push_back(v(1, 0, 32'h101, 0, MS_HALF, 0, 0, 0, 0, 4'hF, 0, 1));
`ifdef MEM_SUBWORD_EN
    tbl.push_back(v(1, 0, 32'h103, 0, MS_BYTE, 1, 32'h80123456, 1, 32'hFFFFFF80, 4'hF, 0, 0));
    tbl.push_back(v(1, 0, 32'h102, 0, MS_HALF, 0, 32'h80123456, 0, 32'h00008012, 4'hF, 0, 0));
    tbl.push_back(v(0, 1, 32'h101, 32'h5A, MS_BYTE, 0, 0, 0, 0, 4'b0010, 32'h5A5A5A5A, 0));
    tbl.push_back(v(0, 1, 32'h106, 32'h1234ABCD, MS_HALF, 0, 0, 3, 0, 4'b1100, 32'hABCDABCD, 0));
    tbl.push_back(v(1, 0, 32'h100, 0, MS_HALF, 1, 32'hFFFF7FFF, 0, 32'h00007FFF, 4'hF, 0, 0));
    tbl.push_back(v(0, 1, 32'h104, 32'hA1B2C3D4, MS_BYTE, 0, 0, 0, 0, 4'b0001, 32'hD4D4D4D4, 0));
`else
    tbl.push_back(v(1, 0, 32'h103, 0, MS_BYTE, 1, 32'h80123456, 1, 0, 4'hF, 0, 1));
    tbl.push_back(v(1, 0, 32'h102, 0, MS_HALF, 0, 32'h80123456, 0, 0, 4'hF, 0, 1));
    tbl.push_back(v(0, 1, 32'h101, 32'h5A, MS_BYTE, 0, 0, 0, 0, 4'hF, 0, 1));
    tbl.push_back(v(0, 1, 32'h106, 32'h1234ABCD, MS_HALF, 0, 0, 3, 0, 4'hF, 0, 1));
    tbl.push_back(v(1, 0, 32'h100, 0, MS_HALF, 1, 32'hFFFF7FFF, 0, 32'hFFFF7FFF, 4'hF, 0, 0));
    tbl.push_back(v(0, 1, 32'h104, 32'hA1B2C3D4, MS_BYTE, 0, 0, 0, 0, 4'hF, 32'hA1B2C3D4, 0));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_rdm", rdm, 0);
    chk("rst_buserr", buserrm, 0);
    chk("rst_misalign", misalignm, 0);
    chk("rst_stall", stallm, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Acks outside REQ must not start or disturb anything.
    dmem_ack = 1;
    @(posedge clk); #1;
    chk("idle_ack_req", dmem_req, 0);
    chk("idle_ack_stall", stallm, 0);
    chk("idle_ack_rdm", rdm, 0);
    dmem_ack = 0;

    foreach (tbl[i]) run(tbl[i]);

    // Reset in the second REQ cycle abandons the access.
    memreadm = 1; aluoutm = 32'h400; memsizem = MS_WORD; memsignedm = 0;
    @(posedge clk); #1;
    chk("mid_req1", dmem_req, 1);
    @(posedge clk); #1;
    chk("mid_req2", dmem_req, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    memreadm = 0;
    #1;
    chk("mid_rst_idle", stallm, 0);
    chk("mid_rst_buserr", buserrm, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    run(tbl[0]);

    for (int n = 0; n < 40; n++) begin
      logic rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) begin
        aluoutm = $urandom;
        #1;
        chk("rnd_idle_stall", stallm, 0);
        chk("rnd_idle_mis", misalignm, 0);
        @(posedge clk); #1;
        chk("rnd_idle_req", dmem_req, 0);
      end else begin
        run(model(rd, wr, $urandom, $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage access unit for the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It turns the stage's load/store controls into a req/ack transaction on the data-memory port, aligns sub-word data, and stalls the pipeline until the access completes. Its `rdm` output feeds the MEM/WB register's read-data input directly.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum REQ cycles without `dmem_ack` before the access is aborted with a bus error; legal range 2..255.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `memreadm` in 1: load in the MEM stage.
- `memwritem` in 1: store in the MEM stage.
- `aluoutm` in 32: effective byte address.
- `writedatam` in 32: store data, right-justified.
- `memsizem` in 2: access size; 00 byte, 01 half, 10 word, 11 treated as word.
- `memsignedm` in 1: 1 sign-extends sub-word loads; 0 zero-extends them.
- `stallm` out 1: holds IF..EX/MEM while high.
- `rdm` out 32: aligned, extended load data; valid when `stallm` is 0.
- `misalignm` out 1: one-cycle pulse on a misaligned access.
- `buserrm` out 1: one-cycle pulse on a timeout.
- `dmem_req` out 1: request, registered.
- `dmem_we` out 1: write enable, registered.
- `dmem_addr` out 32: word-aligned address (bits [1:0] = 0), registered.
- `dmem_wdata` out 32: lane-positioned write data, registered.
- `dmem_be` out 4: byte enables, registered.
- `dmem_ack` in 1: completion, sampled at the rising edge.
- `dmem_rdata` in 32: read word, valid when `dmem_ack` is 1.

## Operation
- Byte order: little-endian. Byte `n` of a word is bits [8n+7:8n].
- Misalignment:
  - A half access with `aluoutm[0]` = 1 is misaligned.
  - A word access with `aluoutm[1:0]` ≠ 0 is misaligned.
  - A misaligned access issues no request. It raises `misalignm` for the cycle, holds `stallm` at 0, and drives `rdm` to 0. The store is suppressed.
- Stores:
  - Byte: `dmem_be` = 1 << addr[1:0]; byte replicated on all four lanes.
  - Half: `dmem_be` = 0011 if addr[1] = 0, else 1100; half replicated on both halves.
  - Word: `dmem_be` = 1111.
- Loads:
  - Read data is selected by addr[1:0] and extended according to `memsignedm`.
  - Loads drive `dmem_be` = 1111.
- If `memreadm` and `memwritem` are both 1, the store wins and `rdm` = 0.
- State machine, using state names IDLE, REQ, DONE:
  - IDLE: access pending and aligned → `stallm` = 1, load the `dmem_*` registers, go to REQ. No access → `stallm` = 0, `rdm` = 0.
  - REQ: `dmem_req` = 1 and `stallm` = 1; timeout counter increments.
    - `dmem_ack` = 1 → capture aligned data into the `rdm` register, drop `dmem_req`, go to DONE.
    - Counter reaches `TIMEOUT` - 1 without ack → drop `dmem_req`, set `rdm` = 0, pulse `buserrm` during the DONE cycle, go to DONE.
  - DONE: `stallm` = 0; `rdm` holds the captured value; the pipeline advances at this edge; next state is IDLE unconditionally. DONE guarantees the held instruction is never reissued.
- A `dmem_ack` seen in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, counter 0. All outputs are 0 except `stallm`, which is combinational from state and inputs.
- Reset asserted mid-REQ drops `dmem_req` immediately (asynchronous) and abandons the access.
- Latency, with the instruction present at cycle 0:
  - `dmem_req` high from cycle 1.
  - Ack sampled at the end of cycle 1+k (k ≥ 0 wait cycles).
  - DONE in cycle 2+k; total 3+k cycles.
- `stallm` is high in cycles 0..1+k and low in cycle 2+k.
- Timeout case: `dmem_req` high for exactly `TIMEOUT` cycles, then DONE.
- `dmem_*` outputs are stable for the whole REQ phase.
- `dmem_req` is never high in two consecutive transactions without an intervening non-REQ cycle.

## Configuration
- `MEM_SUBWORD_EN` defined:
  - byte/half stores and loads with lane steering and extension as above.
- `MEM_SUBWORD_EN` undefined:
  - `memsizem` and `memsignedm` are ignored and every access is a word access.
  - `dmem_be` is always 1111; `rdm` = `dmem_rdata`.
  - Misalignment is checked on addr[1:0] only.

## Structure
- Shared package `mips_pkg` holds:
  - `memsize` encoding constants: `MS_BYTE`, `MS_HALF`, `MS_WORD`.
  - `mem_state_t` enum for IDLE, REQ, DONE.
- One sub-module, `load_align`: combinational lane select and extension of `dmem_rdata` from addr[1:0], size and signed. It is compiled only under `MEM_SUBWORD_EN`.

## Test plan
- Word load to 0x100, ack with 0 waits, `dmem_rdata` = 0xDEADBEEF:
  - `dmem_req` high 1 cycle; `rdm` = 0xDEADBEEF in DONE; `stallm` high 2 cycles.
- Signed byte load at 0x103, rdata 0x80123456 → `rdm` = 0xFFFFFF80.
- Unsigned half load at 0x102, same rdata → `rdm` = 0x00008012.
- Byte store of 0x5A at 0x101:
  - `dmem_be` = 0010, `dmem_wdata` = 0x5A5A5A5A, `dmem_we` = 1, `dmem_addr` = 0x100.
- Word load at 0x102:
  - `misalignm` pulses; `dmem_req` never rises; `stallm` = 0; `rdm` = 0.
- With `TIMEOUT` = 4, load with no ack:
  - `dmem_req` high exactly 4 cycles; `buserrm` pulses; `rdm` = 0.
  - Repeat with `rst_n` dropped in the 2nd REQ cycle → `dmem_req` falls immediately and the state returns to IDLE.
